// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and counter-width helper for the fetch stage
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Counters must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH x WIDTH synchronous FIFO with flush
// Ports: CLK, RESET (async active-low); push/wdata write the tail; pop retires
// the head; flush empties the FIFO and overrides push/pop; head is the oldest
// entry and count the number of valid entries.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [cnt_w(DEPTH)-1:0]  count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && count != '0;
    assign head    = mem[rd_ptr];

    // Storage is not reset; only pointers and count are.
    always_ff @(posedge CLK)
        if (do_push) mem[wr_ptr] <= wdata;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit_buffered.sv
// fetch_unit_buffered: PC owner and buffered instruction fetch stage
// Ports: CLK, RESET (async active-low); imem_req_* issue sequential word
// fetches; imem_resp_* return words in order; redirect_* retarget fetch and
// flush the buffer; if_* present the buffered instruction to decode.
module fetch_unit_buffered
    import fetch_pkg::*;
#(
    parameter int              XLEN      = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(fetch_pkg::RESET_PC),
    parameter int              BUF_DEPTH = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc4,
    output logic [XLEN-1:0] if_instr
);
    localparam int CW = cnt_w(BUF_DEPTH);

    logic [XLEN-1:0] fetch_pc, head_pc, head_data, target;
    logic [CW-1:0]   count, outstanding, drop, out_next;
    logic            req_fire, push, pop;

    assign target = redirect_pc & ~XLEN'(3);

    // Credit check: every issued request already owns a buffer slot.
    assign imem_req_valid = RESET && (({1'b0, outstanding} + {1'b0, count}) < (CW + 1)'(BUF_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign out_next       = outstanding + CW'(req_fire) - CW'(imem_resp_valid);

    // A response in a redirect cycle is stale even when drop is zero.
    assign push = imem_resp_valid && drop == '0 && !redirect_valid;
    assign pop  = if_valid && if_ready;

    assign if_valid = count != '0;
    assign if_pc    = head_pc;
    assign if_pc4   = head_pc + XLEN'(4);
    assign if_instr = if_valid ? head_data : XLEN'(NOP_INSTR);

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (XLEN)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (push),
        .wdata (imem_resp_data),
        .pop   (pop),
        .flush (redirect_valid),
        .head  (head_data),
        .count (count)
    );

    // On redirect, every request still in flight (including one firing now)
    // will return a stale word, so drop is reloaded from outstanding.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fetch_pc    <= RESET_PC;
            head_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= out_next;
            fetch_pc    <= redirect_valid ? target : req_fire ? fetch_pc + XLEN'(4) : fetch_pc;
            head_pc     <= redirect_valid ? target : pop ? head_pc + XLEN'(4) : head_pc;
            drop        <= redirect_valid ? out_next :
                           (imem_resp_valid && drop != '0) ? drop - CW'(1) : drop;
        end
    end
endmodule

// File: tb/tb_fetch_unit_buffered.sv
// tb_fetch_unit_buffered: directed bench with an in-order variable-latency IMEM model
module tb_fetch_unit_buffered;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc, if_pc4, if_instr;

    int n_tests = 0, n_fail = 0;
    int lat = 1, cyc = 0, fire_cnt = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] log_pc[$];

    fetch_unit_buffered #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .CLK(CLK), .RESET(RESET),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_pc4(if_pc4), .if_instr(if_instr)
    );

    always #5 CLK = ~CLK;

    // IMEM model: word at address A is A + 0x1000_0000, returned lat cycles after acceptance.
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            q_addr.delete();
            q_due.delete();
            fire_cnt = 0;
        end else begin
            if (imem_resp_valid) begin
                assert (q_addr.size() > 0) else begin
                    n_fail++;
                    $display("FAIL resp_without_request got=%0d exp>0", q_addr.size());
                end
                if (q_addr.size() > 0) begin
                    void'(q_addr.pop_front());
                    void'(q_due.pop_front());
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                q_addr.push_back(imem_req_addr);
                q_due.push_back(cyc + lat);
                fire_cnt++;
            end
            cyc++;
        end
    end

    always @(negedge CLK or negedge RESET) begin
        if (!RESET) begin
            imem_resp_valid = 1'b0;
        end else begin
            imem_resp_valid = q_addr.size() > 0 && q_due[0] <= cyc;
            imem_resp_data  = imem_resp_valid ? q_addr[0] + 32'h1000_0000 : 32'h0;
        end
    end

    // Decode-side monitor: every accepted word must match its PC.
    always @(negedge CLK) begin
        if (RESET && if_valid && if_ready) begin
            log_pc.push_back(if_pc);
            n_tests++;
            if (if_instr !== if_pc + 32'h1000_0000) begin
                n_fail++;
                $display("FAIL mon_instr pc=%h got=%h exp=%h", if_pc, if_instr, if_pc + 32'h1000_0000);
            end
            n_tests++;
            if (if_pc4 !== if_pc + 32'd4) begin
                n_fail++;
                $display("FAIL mon_pc4 got=%h exp=%h", if_pc4, if_pc + 32'd4);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int l);
        RESET = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        lat = l;
        tick(2);
        RESET = 1'b1;
        log_pc.delete();
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        if_ready = 1'b0;
        lat = 1;
        tick(2);
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_if_valid got=%b exp=0", if_valid); end
        n_tests++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got=%h exp=0", imem_req_addr); end
        n_tests++; if (if_pc !== 32'h0 || if_pc4 !== 32'h4) begin n_fail++; $display("FAIL rst_pc got=%h/%h exp=0/4", if_pc, if_pc4); end
        RESET = 1'b1;
        #1;
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL first_req got=%b@%h exp=1@0", imem_req_valid, imem_req_addr); end
        tick();
        n_tests++; if (if_valid !== 1'b0 || imem_req_addr !== 32'h4) begin n_fail++; $display("FAIL after_fire got=%b@%h exp=0@4", if_valid, imem_req_addr); end
        tick();
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h1000_0000) begin n_fail++; $display("FAIL first_word got=%b %h %h exp=1 0 10000000", if_valid, if_pc, if_instr); end
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL credit_full got=%b exp=0", imem_req_valid); end
    endtask

    task automatic test_stream;
        do_reset(1);
        if_ready = 1'b1;
        tick(20);
        n_tests++; if (log_pc.size() < 8) begin n_fail++; $display("FAIL stream_count got=%0d exp>=8", log_pc.size()); end
        foreach (log_pc[i]) begin
            n_tests++; if (log_pc[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, log_pc[i], 32'(4 * i)); end
        end
    endtask

    task automatic test_stall;
        do_reset(1);
        tick(10);
        n_tests++; if (fire_cnt !== 2) begin n_fail++; $display("FAIL stall_fires got=%0d exp=2", fire_cnt); end
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_req got=%b exp=0", imem_req_valid); end
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin n_fail++; $display("FAIL stall_head got=%b@%h exp=1@0", if_valid, if_pc); end
        if_ready = 1'b1;
        tick(6);
        n_tests++; if (log_pc.size() < 3) begin n_fail++; $display("FAIL stall_release_count got=%0d exp>=3", log_pc.size()); end
        foreach (log_pc[i]) begin
            n_tests++; if (log_pc[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, log_pc[i], 32'(4 * i)); end
        end
    endtask

    task automatic test_redirect_late;
        do_reset(3);
        tick(2);
        n_tests++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL late_pre got=%b/%b exp=0/0", imem_req_valid, if_valid); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL late_flush got=%b exp=0", if_valid); end
        n_tests++; if (imem_req_addr !== 32'h100 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL late_req got=%b@%h exp=0@100", imem_req_valid, imem_req_addr); end
        if_ready = 1'b1;
        log_pc.delete();
        tick(20);
        n_tests++; if (log_pc.size() < 2) begin n_fail++; $display("FAIL late_count got=%0d exp>=2", log_pc.size()); end
        foreach (log_pc[i]) begin
            n_tests++; if (log_pc[i] !== 32'h100 + 32'(4 * i)) begin n_fail++; $display("FAIL late_pc[%0d] got=%h exp=%h", i, log_pc[i], 32'h100 + 32'(4 * i)); end
        end
    endtask

    task automatic test_misaligned;
        do_reset(1);
        if_ready = 1'b1;
        tick(5);
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        tick();
        redirect_valid = 1'b0;
        log_pc.delete();
        n_tests++; if (imem_req_addr !== 32'h200 || if_pc !== 32'h200) begin n_fail++; $display("FAIL align got=%h/%h exp=200/200", imem_req_addr, if_pc); end
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL align_flush got=%b exp=0", if_valid); end
        tick(15);
        n_tests++; if (log_pc.size() < 2) begin n_fail++; $display("FAIL align_count got=%0d exp>=2", log_pc.size()); end
        foreach (log_pc[i]) begin
            n_tests++; if (log_pc[i] !== 32'h200 + 32'(4 * i)) begin n_fail++; $display("FAIL align_pc[%0d] got=%h exp=%h", i, log_pc[i], 32'h200 + 32'(4 * i)); end
        end
    endtask

    task automatic test_coincident;
        do_reset(1);
        tick();
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin n_fail++; $display("FAIL coin_pre got=%b@%h exp=1@4", imem_req_valid, imem_req_addr); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL coin_discard got=%b exp=0", if_valid); end
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin n_fail++; $display("FAIL coin_req got=%b@%h exp=1@300", imem_req_valid, imem_req_addr); end
        if_ready = 1'b1;
        log_pc.delete();
        tick(12);
        n_tests++; if (log_pc.size() < 2) begin n_fail++; $display("FAIL coin_count got=%0d exp>=2", log_pc.size()); end
        foreach (log_pc[i]) begin
            n_tests++; if (log_pc[i] !== 32'h300 + 32'(4 * i)) begin n_fail++; $display("FAIL coin_pc[%0d] got=%h exp=%h", i, log_pc[i], 32'h300 + 32'(4 * i)); end
        end
    endtask

    task automatic test_back_to_back;
        do_reset(3);
        tick(2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        tick();
        redirect_pc = 32'h500;
        tick();
        redirect_valid = 1'b0;
        n_tests++; if (if_pc !== 32'h500 || imem_req_addr !== 32'h500) begin n_fail++; $display("FAIL b2b_target got=%h/%h exp=500/500", if_pc, imem_req_addr); end
        if_ready = 1'b1;
        log_pc.delete();
        tick(20);
        n_tests++; if (log_pc.size() < 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp>=2", log_pc.size()); end
        foreach (log_pc[i]) begin
            n_tests++; if (log_pc[i] !== 32'h500 + 32'(4 * i)) begin n_fail++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", i, log_pc[i], 32'h500 + 32'(4 * i)); end
        end
    endtask

    task automatic test_reset_mid;
        do_reset(1);
        tick(6);
        n_tests++; if (if_valid !== 1'b1 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_full got=%b/%b exp=1/0", if_valid, imem_req_valid); end
        #2;
        RESET = 1'b0;
        #1;
        n_tests++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async got=%b/%b exp=0/0", if_valid, imem_req_valid); end
        n_tests++; if (if_pc !== 32'h0 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL mid_pc got=%h/%h exp=0/0", if_pc, imem_req_addr); end
        tick();
        RESET = 1'b1;
        #1;
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL mid_restart got=%b@%h exp=1@0", imem_req_valid, imem_req_addr); end
        if_ready = 1'b1;
        log_pc.delete();
        tick(10);
        n_tests++; if (log_pc.size() < 2) begin n_fail++; $display("FAIL mid_count got=%0d exp>=2", log_pc.size()); end
        foreach (log_pc[i]) begin
            n_tests++; if (log_pc[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL mid_pc[%0d] got=%h exp=%h", i, log_pc[i], 32'(4 * i)); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_late();
        test_misaligned();
        test_coincident();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
